ram_dma_copier: RTL and testbench



---
 rtl/ram_dma_copier_if.sv | 22 ++
 rtl/ram_dma_copier.sv | 144 ++++++++++++++
 tb/tb_ram_dma_copier.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dma_copier_if.sv
// RAM port bundle between the DMA copier (master) and the shared RAM/arbiter (slave).
// The RAM reads combinationally and writes on the clock edge when mem_enw is high.
interface ram_dma_copier_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_gnt;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_enw;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_address, mem_wdata, mem_enw,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_address, mem_wdata, mem_enw,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/ram_dma_copier.sv
// Word-block DMA copier sharing the RAM port through a req/gnt handshake.
// Define RAM_DMA_STRIDE_EN to add 2-D strided addressing (row_len/src_stride/dst_stride).
module ram_dma_copier #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src_addr,
  input  logic [WIDTH-1:0] dst_addr,
  input  logic [LEN_W-1:0] length,
`ifdef RAM_DMA_STRIDE_EN
  input  logic [LEN_W-1:0] row_len,
  input  logic [WIDTH-1:0] src_stride,
  input  logic [WIDTH-1:0] dst_stride,
`endif
  output logic             busy,
  output logic             done,
  ram_dma_copier_if.master mem
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] src_cur_reg, dst_cur_reg;
  logic [LEN_W-1:0] count_reg;
  logic [WIDTH-1:0] buf_reg;
  logic [WIDTH-1:0] src_step, dst_step;

`ifdef RAM_DMA_STRIDE_EN
  logic [LEN_W-1:0] row_len_reg, row_cnt_reg;
  logic [WIDTH-1:0] src_stride_reg, dst_stride_reg;
  logic [WIDTH-1:0] src_base_reg, dst_base_reg;
  logic             row_end;

  // A zero row length disables the row jump, leaving plain linear addressing.
  assign row_end  = (row_len_reg != '0) && (row_cnt_reg == row_len_reg - LEN_W'(1));
  assign src_step = row_end ? src_base_reg + src_stride_reg : src_cur_reg + WIDTH'(1);
  assign dst_step = row_end ? dst_base_reg + dst_stride_reg : dst_cur_reg + WIDTH'(1);
`else
  assign src_step = src_cur_reg + WIDTH'(1);
  assign dst_step = dst_cur_reg + WIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (length == '0) ? FIN : RD;
        end
      end
      RD: begin
        if (mem.mem_gnt) begin
          state_next = WR;
        end
      end
      WR: begin
        if (mem.mem_gnt) begin
          state_next = (count_reg == LEN_W'(1)) ? FIN : RD;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_cur_reg    <= '0;
      dst_cur_reg    <= '0;
      count_reg      <= '0;
      buf_reg        <= '0;
`ifdef RAM_DMA_STRIDE_EN
      row_len_reg    <= '0;
      row_cnt_reg    <= '0;
      src_stride_reg <= '0;
      dst_stride_reg <= '0;
      src_base_reg   <= '0;
      dst_base_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && (length != '0)) begin
            src_cur_reg    <= src_addr;
            dst_cur_reg    <= dst_addr;
            count_reg      <= length;
`ifdef RAM_DMA_STRIDE_EN
            row_len_reg    <= row_len;
            row_cnt_reg    <= '0;
            src_stride_reg <= src_stride;
            dst_stride_reg <= dst_stride;
            src_base_reg   <= src_addr;
            dst_base_reg   <= dst_addr;
`endif
          end
        end
        RD: begin
          if (mem.mem_gnt) begin
            buf_reg <= mem.mem_rdata;
          end
        end
        WR: begin
          if (mem.mem_gnt) begin
            src_cur_reg <= src_step;
            dst_cur_reg <= dst_step;
            count_reg   <= count_reg - LEN_W'(1);
`ifdef RAM_DMA_STRIDE_EN
            if (row_end) begin
              src_base_reg <= src_step;
              dst_base_reg <= dst_step;
              row_cnt_reg  <= '0;
            end else begin
              row_cnt_reg  <= row_cnt_reg + LEN_W'(1);
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Everything below decodes state/registers only; the write strobe alone follows
  // the grant, and is masked by reset so nothing lands on a reset edge.
  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == FIN);
  assign mem.mem_req     = (state_reg == RD) || (state_reg == WR);
  assign mem.mem_address = (state_reg == RD) ? src_cur_reg :
                           (state_reg == WR) ? dst_cur_reg : '0;
  assign mem.mem_wdata   = (state_reg == WR) ? buf_reg : '0;
  assign mem.mem_enw     = (state_reg == WR) && mem.mem_gnt && rst_n;

endmodule

// File: tb/tb_ram_dma_copier.sv
// Self-checking bench for ram_dma_copier: RAM model, write scoreboard, cycle/latency checks.
// Stride scenario runs only when RAM_DMA_STRIDE_EN is defined.
module tb_ram_dma_copier;
  localparam int WIDTH = 32;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] src_addr = '0;
  logic [WIDTH-1:0] dst_addr = '0;
  logic [LEN_W-1:0] length = '0;
`ifdef RAM_DMA_STRIDE_EN
  logic [LEN_W-1:0] row_len = '0;
  logic [WIDTH-1:0] src_stride = '0;
  logic [WIDTH-1:0] dst_stride = '0;
`endif
  logic             busy, done;
  logic             gnt = 1'b0;

  ram_dma_copier_if #(.WIDTH(WIDTH)) mem_if ();

  ram_dma_copier #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
`ifdef RAM_DMA_STRIDE_EN
    .row_len    (row_len),
    .src_stride (src_stride),
    .dst_stride (dst_stride),
`endif
    .busy       (busy),
    .done       (done),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  // RAM model: 1024 words, address aliased on the low 10 bits.
  logic [31:0] ram   [0:1023];
  logic [31:0] model [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a = '0;
  logic [31:0] pre_d = '0;

  assign mem_if.mem_gnt   = gnt;
  assign mem_if.mem_rdata = ram[mem_if.mem_address[9:0]];

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_if.mem_enw) ram[mem_if.mem_address[9:0]] <= mem_if.mem_wdata;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  logic [31:0] dst_q[$];
  int          wr_cnt = 0;

  always @(negedge clk) begin : wr_monitor
    wr_t e;
    if (mem_if.mem_enw === 1'b1) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", mem_if.mem_address, e.addr);
        check("wr_data", mem_if.mem_wdata, e.data);
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_a  = a[9:0];
    pre_d  = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    model[a[9:0]] = d;
  endtask

  // Expected write stream from a reference walk of the copy (row/column addressing).
  task automatic plan(input logic [31:0] s, input logic [31:0] d, input int len,
                      input int rl, input logic [31:0] ss, input logic [31:0] ds,
                      input int maxw);
    logic [31:0] sa, da;
    int          row, col;
    wr_t         e;
    for (int k = 0; k < len && k < maxw; k++) begin
      if (rl != 0) begin
        row = k / rl;
        col = k % rl;
      end else begin
        row = 0;
        col = k;
      end
      sa = s + 32'(row) * ss + 32'(col);
      da = d + 32'(row) * ds + 32'(col);
      e.addr = da;
      e.data = model[sa[9:0]];
      model[da[9:0]] = e.data;
      sb_q.push_back(e);
      dst_q.push_back(da);
    end
  endtask

  task automatic run(input string name, input logic [31:0] s, input logic [31:0] d,
                     input int len, input int rl, input logic [31:0] ss, input logic [31:0] ds,
                     input int stall_at, input int stall_n, input int rst_at, input int ign_at,
                     input int exp_writes, input int exp_done);
    int c, done_c, busy_cnt, req_cnt;
    bit fin;
    logic [31:0] a;
    plan(s, d, len, rl, ss, ds, exp_writes);
    wr_cnt   = 0;
    src_addr = s;
    dst_addr = d;
    length   = LEN_W'(len);
`ifdef RAM_DMA_STRIDE_EN
    row_len    = LEN_W'(rl);
    src_stride = ss;
    dst_stride = ds;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0; done_c = 0; busy_cnt = 0; req_cnt = 0; fin = 0;
    while (!fin) begin
      c++;
      gnt   = (stall_n > 0 && c >= stall_at && c < stall_at + stall_n) ? 1'b0 : 1'b1;
      rst_n = (c == rst_at) ? 1'b0 : 1'b1;
      start = (c == ign_at);
      if (c == ign_at) begin
        src_addr = 32'h3F0;
        dst_addr = 32'h3F8;
        length   = 16'd7;
      end
      @(negedge clk);
      if (!gnt) check("enw_while_gnt_low", mem_if.mem_enw, 0);
      if (c == rst_at) check("enw_on_reset", mem_if.mem_enw, 0);
      if (done_c != 0) begin
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        fin = 1;
      end else begin
        if (busy) busy_cnt++;
        if (mem_if.mem_req) req_cnt++;
        if (done) done_c = c;
      end
      if (rst_at != 0 && c == rst_at + 1) begin
        check("rst_busy", busy, 0);
        check("rst_req", mem_if.mem_req, 0);
        check("rst_addr", mem_if.mem_address, 0);
        check("rst_wdata", mem_if.mem_wdata, 0);
        fin = 1;
      end
      if (c >= 400) begin
        check("timeout", 1, 0);
        fin = 1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    gnt   = 1'b0;
    rst_n = 1'b1;
    check("done_cycle", done_c, exp_done);
    check("busy_cycles", busy_cnt, (exp_done != 0) ? exp_done : rst_at);
    check("req_cycles", req_cnt, (exp_done != 0) ? exp_done - 1 : rst_at);
    check("write_count", wr_cnt, exp_writes);
    check("sb_empty", sb_q.size(), 0);
    sb_q.delete();
    while (dst_q.size() > 0) begin
      a = dst_q.pop_front();
      check("ram_word", ram[a[9:0]], model[a[9:0]]);
    end
    $display("copy %s src=%h dst=%h len=%0d done_cycle=%0d writes=%0d",
             name, s, d, len, done_c, wr_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_req", mem_if.mem_req, 0);
    check("reset_enw", mem_if.mem_enw, 0);
    check("reset_addr", mem_if.mem_address, 0);
    check("reset_wdata", mem_if.mem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Linear copy: done in cycle 9.
    for (int i = 0; i < 4; i++) load(32'h10 + 32'(i), $urandom);
    run("linear", 32'h10, 32'h100, 4, 0, 0, 0, 0, 0, 0, 0, 4, 9);

    // Zero length: done in cycle 1, no RAM traffic.
    run("zero_len", 32'h10, 32'h180, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Grant low for 3 cycles during the first WR: done in cycle 8.
    for (int i = 0; i < 2; i++) load(32'h20 + 32'(i), $urandom);
    run("stall", 32'h20, 32'h120, 2, 0, 0, 0, 2, 3, 0, 0, 2, 8);

    // Reset while the 3rd WR is presented (cycle 6): two writes, no done.
    for (int i = 0; i < 5; i++) load(32'h30 + 32'(i), $urandom);
    run("reset_mid", 32'h30, 32'h140, 5, 0, 0, 0, 0, 0, 6, 0, 2, 0);

    // Start pulsed mid-copy is ignored.
    for (int i = 0; i < 4; i++) load(32'h40 + 32'(i), $urandom);
    run("ignored_start", 32'h40, 32'h160, 4, 0, 0, 0, 0, 0, 0, 3, 4, 9);

    // Overlap dst=src+1 replicates the first word.
    load(32'h0, $urandom);
    run("overlap", 32'h0, 32'h1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 7);
    check("overlap_rep", ram[3], ram[0]);

    // Source address wraps from all-ones to zero.
    load(32'hFFFF_FFFF, $urandom);
    load(32'h0, $urandom);
    run("wrap", 32'hFFFF_FFFF, 32'h200, 2, 0, 0, 0, 0, 0, 0, 0, 2, 5);

`ifdef RAM_DMA_STRIDE_EN
    // 8x8 block out of a 64-word-wide image into a contiguous buffer.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        load(32'h20 + 32'(r * 64 + c), $urandom);
    run("stride_8x8", 32'h20, 32'h300, 64, 8, 32'd64, 32'd8, 0, 0, 0, 0, 64, 129);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
